// File: rtl/ascon_cipher_out_buffer.sv
// ascon_cipher_out_buffer
//   Output stage behind the Ascon control FSM and datapath. Ciphertext blocks
//   are pushed into a small first-word-fall-through FIFO on the cipher-valid
//   pulse. The tag is latched on the end pulse. Words are streamed to the host
//   over a valid/ready port with a last-word marker.
//   Optional macro ASCON_TAG_STREAM_EN: after the ciphertext has drained, the
//   128-bit tag is also streamed as two words (high half first). In that build
//   out_last_o marks the low tag word.
module ascon_cipher_out_buffer #(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [63:0]       cipher_i,
  input  logic              cipher_valid_i,
  input  logic [127:0]      tag_i,
  input  logic              tag_valid_i,
  output logic [63:0]       out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic [127:0]      tag_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   level_o
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_LVL  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_DRAIN   = 3'd2
`ifdef ASCON_TAG_STREAM_EN
    ,
    S_TAG_HI  = 3'd3,
    S_TAG_LO  = 3'd4
`endif
  } state_t;

  state_t              state_q;
  logic [63:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W:0]     level_q;
  logic [127:0]        tag_q;
  logic                overflow_q;
  logic                done_q;

  logic fifo_state;
  logic fifo_valid;
  logic full;
  logic push_req;
  logic do_push;
  logic do_pop;

  // Push/pop decisions; a start pulse discards both because it flushes the FIFO.
  always_comb begin
    fifo_state = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    fifo_valid = fifo_state && (level_q != '0);
    full       = (level_q == FULL_LVL);
    push_req   = (state_q == S_COLLECT) && cipher_valid_i && !start_i;
    do_pop     = fifo_valid && out_ready_i && !start_i;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    do_push    = push_req && (!full || do_pop);
  end

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= cipher_i;
    end
  end

  // Control FSM, FIFO pointers/occupancy, tag latch and status flags.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tag_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        state_q    <= S_COLLECT;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        tag_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
        if (do_push && !do_pop) begin
          level_q <= level_q + ONE_LVL;
        end else if (!do_push && do_pop) begin
          level_q <= level_q - ONE_LVL;
        end
        if (push_req && !do_push) begin
          overflow_q <= 1'b1;
        end

        case (state_q)
          S_COLLECT: begin
            if (tag_valid_i) begin
              tag_q   <= tag_i;
              state_q <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (level_q == '0) begin
`ifdef ASCON_TAG_STREAM_EN
              state_q <= S_TAG_HI;
`else
              done_q  <= 1'b1;
              state_q <= S_IDLE;
`endif
            end
          end
`ifdef ASCON_TAG_STREAM_EN
          S_TAG_HI: begin
            if (out_ready_i) begin
              state_q <= S_TAG_LO;
            end
          end
          S_TAG_LO: begin
            if (out_ready_i) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  // Output word mux: FIFO head while ciphertext is pending, tag halves afterwards.
  always_comb begin
    out_data_o  = '0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    if (fifo_valid) begin
      out_valid_o = 1'b1;
      out_data_o  = mem_q[rd_ptr_q];
`ifndef ASCON_TAG_STREAM_EN
      out_last_o  = (state_q == S_DRAIN) && (level_q == ONE_LVL);
`endif
    end
`ifdef ASCON_TAG_STREAM_EN
    else if (state_q == S_TAG_HI) begin
      out_valid_o = 1'b1;
      out_data_o  = tag_q[127:64];
    end else if (state_q == S_TAG_LO) begin
      out_valid_o = 1'b1;
      out_data_o  = tag_q[63:0];
      out_last_o  = 1'b1;
    end
`endif
  end

  assign tag_o      = tag_q;
  assign done_o     = done_q;
  assign overflow_o = overflow_q;
  assign level_o    = level_q;

endmodule

// File: tb/tb_ascon_cipher_out_buffer.sv
// Bench for ascon_cipher_out_buffer: a queue-based reference model updated on
// each rising edge, and a monitor on the falling edge. The monitor compares the
// DUT against the model and pops the expected-word queue on every expected
// handshake. Directed scenarios are followed by randomized messages.
module tb_ascon_cipher_out_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef ASCON_TAG_STREAM_EN
  localparam int TAGW  = 2;
`else
  localparam int TAGW  = 0;
`endif

  logic          clk = 1'b0;
  logic          srst;
  logic          start;
  logic [63:0]   cipher;
  logic          cv;
  logic [127:0]  tag;
  logic          tv;
  logic          ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic [127:0]  tag_out;
  logic          done;
  logic          ovf;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  ascon_cipher_out_buffer #(.DEPTH(DEPTH)) dut (
    .clock_i        (clk),
    .reset_i        (srst),
    .start_i        (start),
    .cipher_i       (cipher),
    .cipher_valid_i (cv),
    .tag_i          (tag),
    .tag_valid_i    (tv),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (ready),
    .out_last_o     (out_last),
    .tag_o          (tag_out),
    .done_o         (done),
    .overflow_o     (ovf),
    .level_o        (level)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int hs_count = 0;

  typedef enum int {M_IDLE, M_COLLECT, M_DRAIN, M_TAGHI, M_TAGLO} mstate_t;
  mstate_t      mstate = M_IDLE;
  logic [63:0]  exp_q[$];
  logic [127:0] mtag = '0;
  bit           movf = 0;
  bit           mdone = 0;
  bit           mon_pop = 0;
  bit           live = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: one message at a time, FIFO kept as a queue of expected words.
  always @(posedge clk) begin
    int lvl_pre;
    lvl_pre = exp_q.size() + (mon_pop ? 1 : 0);
    if (srst) begin
      live   = 1;
      mstate = M_IDLE;
      exp_q.delete();
      mtag   = '0;
      movf   = 0;
      mdone  = 0;
    end else if (live) begin
      mdone = 0;
      if (start) begin
        exp_q.delete();
        mtag   = '0;
        movf   = 0;
        mstate = M_COLLECT;
      end else begin
        case (mstate)
          M_COLLECT: begin
            if (cv) begin
              if (lvl_pre == DEPTH && !mon_pop) movf = 1;
              else exp_q.push_back(cipher);
            end
            if (tv) begin
              mtag   = tag;
              mstate = M_DRAIN;
            end
          end
          M_DRAIN: begin
            if (lvl_pre == 0) begin
              if (TAGW != 0) mstate = M_TAGHI;
              else begin
                mdone  = 1;
                mstate = M_IDLE;
              end
            end
          end
          M_TAGHI: if (ready) mstate = M_TAGLO;
          M_TAGLO: if (ready) begin
            mdone  = 1;
            mstate = M_IDLE;
          end
          default: ;
        endcase
      end
    end
    mon_pop = 0;
  end

  // Monitor: compare every visible output against the model, pop on handshake.
  always @(negedge clk) begin
    if (live && !srst) begin
      bit          ev;
      bit          el;
      logic [63:0] ed;
      ev = ((mstate == M_COLLECT || mstate == M_DRAIN) && exp_q.size() != 0)
           || mstate == M_TAGHI || mstate == M_TAGLO;
      check("level", 128'(level), 128'(exp_q.size()));
      check("overflow", 128'(ovf), 128'(movf));
      check("tag_o", tag_out, mtag);
      check("done", 128'(done), 128'(mdone));
      check("valid", 128'(out_valid), 128'(ev));
      if (out_valid && ready) hs_count++;
      if (ev) begin
        if (mstate == M_TAGHI)      ed = mtag[127:64];
        else if (mstate == M_TAGLO) ed = mtag[63:0];
        else                        ed = exp_q[0];
        if (TAGW != 0) el = (mstate == M_TAGLO);
        else           el = (mstate == M_DRAIN) && (exp_q.size() == 1);
        check("data", 128'(out_data), 128'(ed));
        check("last", 128'(out_last), 128'(el));
        if (ready) begin
          $display("word %h last %b", out_data, out_last);
          if (mstate == M_COLLECT || mstate == M_DRAIN) begin
            void'(exp_q.pop_front());
            mon_pop = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 0;
    cv    = 0;
    tv    = 0;
  endtask

  task automatic push_word(input logic [63:0] w);
    cipher = w;
    cv     = 1;
    tick();
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (rnd) ready = ($urandom % 4) != 0;
      tick();
      n++;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: done_o=%b after %0d cycles, required 1", done, budget);
    end
  endtask

  initial begin
    int hs0;
    srst = 1; start = 0; cipher = '0; cv = 0; tag = '0; tv = 0; ready = 0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start  = 1'($urandom);
      cv     = 1'($urandom);
      tv     = 1'($urandom);
      ready  = 1'($urandom);
      cipher = {$urandom, $urandom};
      tag    = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_last", 128'(out_last), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_ovf", 128'(ovf), 128'(0));
      check("rst_tag", tag_out, 128'(0));
      check("rst_data", 128'(out_data), 128'(0));
      check("rst_level", 128'(level), 128'(0));
    end
    srst = 0; start = 0; cv = 0; tv = 0; ready = 0;
    tick();

    // 2: four words streamed with ready high, then tag
    ready = 1;
    start = 1; tick();
    hs0 = hs_count;
    for (int i = 1; i <= 4; i++) begin
      push_word(64'(i));
      tick();
    end
    tag = 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A;
    tv  = 1; tick();
    wait_done(50, 0);
    check("t2_words", 128'(hs_count - hs0), 128'(4 + TAGW));
    check("t2_tag", tag_out, 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A);

    // 3: overflow with ready low, drain, then start clears the flag
    ready = 0;
    start = 1; tick();
    for (int i = 1; i <= 5; i++) push_word(64'h100 + 64'(i));
    @(negedge clk);
    check("t3_level", 128'(level), 128'(4));
    check("t3_ovf", 128'(ovf), 128'(1));
    tag = {$urandom, $urandom, $urandom, $urandom};
    tv  = 1; tick();
    ready = 1;
    wait_done(50, 0);
    start = 1; tick();
    @(negedge clk);
    check("t3_ovf_clr", 128'(ovf), 128'(0));

    // 4: full FIFO, push and pop in the same cycle
    ready = 0;
    for (int i = 1; i <= 4; i++) push_word(64'h200 + 64'(i));
    ready = 1;
    push_word(64'h205);
    ready = 0;
    @(negedge clk);
    check("t4_level", 128'(level), 128'(4));
    check("t4_ovf", 128'(ovf), 128'(0));
    tv = 1; tick();
    ready = 1;
    wait_done(50, 0);

    // 5: start in the middle of DRAIN with two words pending
    ready = 0;
    start = 1; tick();
    push_word(64'h301);
    push_word(64'h302);
    tag = 128'h1234;
    tv  = 1; tick();
    tick();
    start = 1; tick();
    @(negedge clk);
    check("t5_level", 128'(level), 128'(0));
    check("t5_tag", tag_out, 128'(0));
    check("t5_done", 128'(done), 128'(0));
    tv = 1; tick();
    wait_done(20, 0);

`ifdef ASCON_TAG_STREAM_EN
    // 6: one block followed by the streamed tag
    ready = 1;
    start = 1; tick();
    hs0 = hs_count;
    push_word(64'hCAFE);
    tag = 128'h0011223344556677_8899AABBCCDDEEFF;
    tv  = 1; tick();
    wait_done(50, 0);
    check("t6_words", 128'(hs_count - hs0), 128'(3));
`endif

    // Randomized messages
    for (int m = 0; m < 40; m++) begin
      int ncyc;
      start = 1; tick();
      ncyc = $urandom_range(12, 2);
      for (int c = 0; c < ncyc; c++) begin
        ready  = ($urandom % 3) == 0;
        cv     = 1'($urandom);
        cipher = {$urandom, $urandom};
        tick();
      end
      tag = {$urandom, $urandom, $urandom, $urandom};
      tv  = 1;
      tick();
      if (($urandom % 6) == 0) begin
        ready = 0;
        tick();
      end else begin
        wait_done(200, 1);
      end
    end

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
